// File: rtl/work_collector.sv
// work_collector: merges NUM_PE per-PE result streams into a single output
// stream using fair round-robin arbitration and one registered output stage.
// Sustains one word per cycle; per-PE word order is preserved.
// Optional build macro: WORK_COLLECTOR_PE_TAG_EN adds the out_pe port carrying
// the source PE index of out_data.
module work_collector #(
  parameter int NUM_PE         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int PE_INDEX_WIDTH = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_PE-1:0]              in_valid,
  output logic [NUM_PE-1:0]              in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CNT_WIDTH-1:0]           out_count,
  output logic                           idle
`ifdef WORK_COLLECTOR_PE_TAG_EN
  ,
  output logic [PE_INDEX_WIDTH-1:0]      out_pe
`endif
);

  localparam logic [PE_INDEX_WIDTH-1:0] LAST_PE = PE_INDEX_WIDTH'(NUM_PE - 1);

  // Round-robin successor; wraps at NUM_PE-1 so non-power-of-2 counts work.
  function automatic logic [PE_INDEX_WIDTH-1:0] next_pe(input logic [PE_INDEX_WIDTH-1:0] p);
    next_pe = (p == LAST_PE) ? '0 : p + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0]     pe_word [NUM_PE];
  logic [PE_INDEX_WIDTH-1:0] rr_ptr;
  logic [PE_INDEX_WIDTH-1:0] cand;
  logic [PE_INDEX_WIDTH-1:0] grant;
  logic                      grant_vld;
  logic [DATA_WIDTH-1:0]     grant_data;
  logic                      load_en;
  logic                      accept;

  logic [DATA_WIDTH-1:0]     data_p1;
  logic                      vld_p1;
  logic [CNT_WIDTH-1:0]      emit_cnt;

  // Split the flat input bus into one word per PE.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      pe_word[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search for the first valid PE starting at rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = rr_ptr;
    for (int k = 0; k < NUM_PE; k++) begin
      if (!grant_vld && in_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
      cand = next_pe(cand);
    end
  end

  // The stage can take a word when empty or draining this cycle; nothing is
  // accepted while reset is held so upstream PEs keep their words.
  assign load_en    = !vld_p1 || out_ready;
  assign accept     = rst_n && load_en && grant_vld;
  assign grant_data = pe_word[grant];

  // One-hot accept strobe back to the granted PE only.
  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  // ---- stage p0 -> p1: output register, pointer advance, emit counter ----
  // Output stage, arbitration pointer and emitted-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      rr_ptr   <= '0;
      emit_cnt <= '0;
    end else begin
      if (load_en) begin
        vld_p1 <= grant_vld;
      end
      if (accept) begin
        data_p1 <= grant_data;
        rr_ptr  <= next_pe(grant);
      end
      if (vld_p1 && out_ready) begin
        emit_cnt <= emit_cnt + CNT_WIDTH'(1);
      end
    end
  end

`ifdef WORK_COLLECTOR_PE_TAG_EN
  logic [PE_INDEX_WIDTH-1:0] pe_p1;

  // Source-PE tag registered alongside the data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_p1 <= '0;
    end else if (accept) begin
      pe_p1 <= grant;
    end
  end

  assign out_pe = pe_p1;
`endif

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_count = emit_cnt;
  assign idle      = !(|in_valid) && !vld_p1;

endmodule

// File: tb/tb_work_collector.sv
// Directed bench for work_collector (NUM_PE=4, DATA_WIDTH=32) plus a random
// valid/ready soak checked against a scoreboard and a round-robin model.
module tb_work_collector;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam logic [31:0] T2E [8] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0,
                                      32'hA1, 32'hB1, 32'hC1, 32'hD1};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_count;
  logic              idle;
`ifdef WORK_COLLECTOR_PE_TAG_EN
  logic [1:0]        out_pe;
`endif

  always #5 clk = ~clk;

  work_collector #(
    .NUM_PE(NP), .DATA_WIDTH(DW), .PE_INDEX_WIDTH(2), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .idle(idle)
`ifdef WORK_COLLECTOR_PE_TAG_EN
    , .out_pe(out_pe)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] pq [NP][$];
  logic [31:0] exp_q [$];
  logic [NP-1:0] en;
  logic [1:0]  rr_m;
  int          ncnt;
  bit          sb_on;
  bit          rnd;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      in_valid[i] = en[i] && (pq[i].size() > 0);
      in_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
  endtask

  // One clock: model accepts, advance across the edge, re-drive inputs.
  task automatic tick();
    logic [NP-1:0] r, er;
    logic          ov, ordy;
    logic [31:0]   od, e;
    logic [1:0]    g, c;
    bit            gv;
    r = in_ready; ov = out_valid; ordy = out_ready; od = out_data;
    gv = 0; g = '0; c = rr_m;
    for (int k = 0; k < NP; k++) begin
      if (!gv && in_valid[c]) begin gv = 1; g = c; end
      c = (c == 2'(NP-1)) ? 2'd0 : c + 2'd1;
    end
    er = '0;
    if (rst_n && (!ov || ordy) && gv) begin
      er[g] = 1'b1;
      rr_m = (g == 2'(NP-1)) ? 2'd0 : g + 2'd1;
    end
    if (sb_on) check_val("soak_in_ready", r, er);
    if (ov && ordy) begin
      ncnt++;
      if (sb_on) begin
        check_val("soak_sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("soak_out_data", od, e);
`ifdef WORK_COLLECTOR_PE_TAG_EN
          check_val("soak_out_pe", out_pe, e[25:24]);
`endif
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (r[i] && pq[i].size() > 0) begin
        if (sb_on) exp_q.push_back(pq[i][0]);
        void'(pq[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (rnd) begin
      for (int i = 0; i < NP; i++) begin
        if (!(in_valid[i] && !r[i])) en[i] = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drive();
    #1;
  endtask

  function automatic bit pending();
    bit p;
    p = out_valid || (exp_q.size() > 0);
    for (int i = 0; i < NP; i++) if (pq[i].size() > 0) p = 1;
    return p;
  endfunction

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; en = '1; in_valid = '0; in_data = '0;
    sb_on = 0; rnd = 0; rr_m = '0; ncnt = 0;
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_count", out_count, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_idle", idle, 1);
    check_val("rst_in_ready", in_ready, 4'b0000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;

    // All PEs valid: strict rotation, one word per cycle.
    pq[0] = '{32'hA0, 32'hA1}; pq[1] = '{32'hB0, 32'hB1};
    pq[2] = '{32'hC0, 32'hC1}; pq[3] = '{32'hD0, 32'hD1};
    drive(); #1;
    check_val("t2_rdy0", in_ready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val("t2_data", out_data, T2E[k]);
      check_val("t2_valid", out_valid, 1);
`ifdef WORK_COLLECTOR_PE_TAG_EN
      check_val("t2_pe", out_pe, 2'(k));
`endif
    end
    tick();
    check_val("t2_drained", out_valid, 0);
    check_val("t2_count", out_count, 8);
    check_val("t2_idle", idle, 1);

    // Only PE2 valid.
    pq[2] = '{32'h22, 32'h23};
    drive(); #1;
    check_val("t3_rdy0", in_ready, 4'b0100);
    tick();
    check_val("t3_data0", out_data, 32'h22);
    check_val("t3_rdy1", in_ready, 4'b0100);
    tick();
    check_val("t3_data1", out_data, 32'h23);
    check_val("t3_valid1", out_valid, 1);
    check_val("t3_rdy2", in_ready, 4'b0000);
    tick();
    check_val("t3_drained", out_valid, 0);
    check_val("t3_hold", out_data, 32'h23);
    check_val("t3_count", out_count, 10);

    // rr_ptr is 3: PE3 before PE0.
    pq[0] = '{32'h50}; pq[3] = '{32'h53};
    drive(); #1;
    check_val("t5_rdy0", in_ready, 4'b1000);
    tick();
    check_val("t5_data0", out_data, 32'h53);
    check_val("t5_rdy1", in_ready, 4'b0001);
    tick();
    check_val("t5_data1", out_data, 32'h50);
    tick();
    check_val("t5_drained", out_valid, 0);
    check_val("t5_count", out_count, 12);

    // Stall with 0x55 in the stage.
    out_ready = 1'b0;
    pq[1] = '{32'h55, 32'h56};
    drive(); #1;
    check_val("t4_rdy_load", in_ready, 4'b0010);
    tick();
    for (int j = 0; j < 5; j++) begin
      check_val("t4_stall_rdy", in_ready, 4'b0000);
      check_val("t4_stall_data", out_data, 32'h55);
      check_val("t4_stall_valid", out_valid, 1);
      check_val("t4_stall_idle", idle, 0);
      tick();
    end
    check_val("t4_stall_end", out_data, 32'h55);
    out_ready = 1'b1; #1;
    check_val("t4_rdy_rel", in_ready, 4'b0010);
    tick();
    check_val("t4_next_data", out_data, 32'h56);
    check_val("t4_next_valid", out_valid, 1);
    check_val("t4_count13", out_count, 13);
    tick();
    check_val("t4_drained", out_valid, 0);
    check_val("t4_count14", out_count, 14);

    // Reset mid-stream with a full, stalled stage.
    out_ready = 1'b0;
    for (int i = 0; i < NP; i++) pq[i] = '{32'h10 + 32'(i)};
    drive(); #1;
    check_val("t1_rdy_pre", in_ready, 4'b0100);
    tick();
    check_val("t1_loaded", out_data, 32'h12);
    check_val("t1_stall_rdy", in_ready, 4'b0000);
    #2;
    rst_n = 1'b0; rr_m = '0; ncnt = 0;
    #1;
    check_val("t1_rst_valid", out_valid, 0);
    check_val("t1_rst_count", out_count, 0);
    check_val("t1_rst_data", out_data, 0);
    check_val("t1_rst_rdy", in_ready, 4'b0000);
`ifdef WORK_COLLECTOR_PE_TAG_EN
    check_val("t1_rst_pe", out_pe, 0);
`endif
    @(posedge clk); #1;
    check_val("t1_rst_rdy_edge", in_ready, 4'b0000);
    check_val("t1_rst_valid_edge", out_valid, 0);
    rst_n = 1'b1; out_ready = 1'b1; #1;
    check_val("t1_first_grant", in_ready, 4'b0001);
    tick();
    check_val("t1_data0", out_data, 32'h10);
    tick();
    check_val("t1_data1", out_data, 32'h11);
    tick();
    check_val("t1_data3", out_data, 32'h13);
    tick();
    check_val("t1_drained", out_valid, 0);
    check_val("t1_count", out_count, 3);

    // Random valid/ready soak against scoreboard and round-robin model.
    for (int i = 0; i < NP; i++) begin
      pq[i].delete();
      for (int j = 0; j < 40; j++) pq[i].push_back({8'(i), 24'(j)});
    end
    exp_q.delete();
    sb_on = 1; rnd = 1;
    drive(); #1;
    for (int c = 0; c < 400; c++) tick();
    rnd = 0; en = '1; out_ready = 1'b1;
    drive(); #1;
    for (int c = 0; c < 400 && pending(); c++) tick();
    check_val("soak_drained", pending(), 0);
    check_val("soak_count", out_count, 32'(ncnt));
    check_val("soak_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
